// File: rtl/shift_add_mul8_if.sv
// Start/done handshake and operand/product bus of the shift-and-add multiplier.
// All buses use [0:n-1] indexing with index 0 as the MSB.
interface shift_add_mul8_if;
  logic        start;
  logic [0:7]  a;
  logic [0:7]  b;
  logic        busy;
  logic        done;
  logic [0:15] p;

  modport master (output start, a, b, input busy, done, p);
  modport slave  (input start, a, b, output busy, done, p);
endinterface

// File: rtl/shift_add_mul8.sv
// Sequential 8x8 unsigned shift-and-add multiplier driving its own eightFADDER.
// One iteration per cycle; 16-bit product is registered after the eighth iteration.
module eightFADDER (
  input  logic [0:7] A,
  input  logic [0:7] B,
  output logic [0:7] R,
  output logic       c_out
);
  // Carry-in is tied to 0; index 0 is the MSB, so the vectors read as plain numbers.
  assign {c_out, R} = {1'b0, A} + {1'b0, B};
endmodule

module shift_add_mul8 (
  input  logic            clk,
  input  logic            rst_n,
  shift_add_mul8_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      r_st;
  state_t      w_st_next;
  logic [0:7]  r_m;
  logic [0:7]  r_a;
  logic [0:7]  r_q;
  logic        r_c;
  logic [2:0]  r_cnt;
  logic [0:15] r_p;

  logic [0:7]  w_r;
  logic        w_cout;
  logic [0:7]  w_sum_a;
  logic        w_sum_c;
  logic [0:7]  w_a_shift;
  logic [0:7]  w_q_shift;

  eightFADDER u_add (
    .A     (r_a),
    .B     (r_m),
    .R     (w_r),
    .c_out (w_cout)
  );

  // C is always 0 entering an iteration, so the no-add branch keeps {C,A}.
  assign w_sum_a   = r_q[7] ? w_r    : r_a;
  assign w_sum_c   = r_q[7] ? w_cout : r_c;
  assign w_a_shift = {w_sum_c, w_sum_a[0:6]};
  assign w_q_shift = {w_sum_a[7], r_q[0:6]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st <= IDLE;
    end else begin
      r_st <= w_st_next;
    end
  end

  always_comb begin
    w_st_next = r_st;
    case (r_st)
      IDLE:    if (bus.start) w_st_next = RUN;
      RUN:     if (r_cnt == 3'd7) w_st_next = DONE;
      DONE:    w_st_next = IDLE;
      default: w_st_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (r_st == RUN);
    bus.done = (r_st == DONE);
    bus.p    = r_p;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m   <= '0;
      r_a   <= '0;
      r_q   <= '0;
      r_c   <= 1'b0;
      r_cnt <= '0;
      r_p   <= '0;
    end else begin
      case (r_st)
        IDLE: begin
          if (bus.start) begin
            r_m   <= bus.a;
            r_q   <= bus.b;
            r_a   <= '0;
            r_c   <= 1'b0;
            r_cnt <= '0;
          end
        end
        RUN: begin
          r_a   <= w_a_shift;
          r_q   <= w_q_shift;
          r_c   <= 1'b0;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_p <= {w_a_shift, w_q_shift};
          end
        end
        default: ;
      endcase
    end
  end
endmodule
